// File: rtl/frame_tick_sync.sv
// frame_tick_sync: synchronizes the toggling frame-rate signal into clk and turns each
// accepted transition into frame/pacman/ghost enable pulses, with frame count and watchdog.
module frame_tick_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int PAC_DIV     = 4,
  parameter int GHOST_DIV   = 5,
  parameter int WD_LIMIT    = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk,
  input  logic        enable,
  output logic        frame_tick,
  output logic        pac_tick,
  output logic        ghost_tick,
  output logic [15:0] frame_count,
  output logic        tick_lost,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    LOST = 2'd3
  } state_t;

  localparam logic [7:0]  PAC_LAST   = 8'(PAC_DIV - 1);
  localparam logic [7:0]  GHOST_LAST = 8'(GHOST_DIV - 1);
  localparam logic [21:0] WD_LAST    = 22'(WD_LIMIT - 1);
  localparam logic [21:0] WD_STOP    = 22'(WD_LIMIT);

  state_t                 state_r, state_next;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   edge_s;
  logic                   accept_s;
  logic [7:0]             pac_cnt_r, pac_cnt_next;
  logic [7:0]             ghost_cnt_r, ghost_cnt_next;
  logic [21:0]            wd_r, wd_next;
  logic [15:0]            count_next;
  logic                   frame_next, pac_next, ghost_next, lost_next;

  // Synchronizer chain plus previous-level flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], slow_clk};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign edge_s = (EDGE_MODE != 0) ? (sync_r[SYNC_STAGES-1] ^ prev_r)
                                   : (sync_r[SYNC_STAGES-1] & ~prev_r);

  // Next-state, counter and registered-output logic
  always_comb begin
    state_next     = state_r;
    accept_s       = 1'b0;
    frame_next     = 1'b0;
    pac_next       = 1'b0;
    ghost_next     = 1'b0;
    count_next     = frame_count;
    pac_cnt_next   = pac_cnt_r;
    ghost_cnt_next = ghost_cnt_r;
    wd_next        = wd_r;
    lost_next      = tick_lost;
    if (!enable) begin
      state_next = IDLE;
      lost_next  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Clearing here means ARM is always entered with fresh counters
          state_next     = ARM;
          lost_next      = 1'b0;
          count_next     = 16'd0;
          pac_cnt_next   = 8'd0;
          ghost_cnt_next = 8'd0;
          wd_next        = 22'd0;
        end
        ARM: begin
          if (edge_s) begin
            state_next = RUN;
          end else begin
            state_next = ARM;
          end
        end
        RUN: begin
          if (edge_s) begin
            accept_s = 1'b1;
          end else if (wd_r == WD_LAST) begin
            state_next = LOST;
            lost_next  = 1'b1;
            wd_next    = WD_STOP;
          end else begin
            wd_next = wd_r + 22'd1;
          end
        end
        LOST: begin
          if (edge_s) begin
            accept_s   = 1'b1;
            state_next = RUN;
          end else begin
            state_next = LOST;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    if (accept_s) begin
      frame_next = 1'b1;
      count_next = frame_count + 16'd1;
      wd_next    = 22'd0;
      pac_next   = (pac_cnt_r == PAC_LAST);
      ghost_next = (ghost_cnt_r == GHOST_LAST);
      pac_cnt_next   = (pac_cnt_r == PAC_LAST) ? 8'd0 : pac_cnt_r + 8'd1;
      ghost_cnt_next = (ghost_cnt_r == GHOST_LAST) ? 8'd0 : ghost_cnt_r + 8'd1;
    end else begin
      frame_next = 1'b0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      frame_tick  <= 1'b0;
      pac_tick    <= 1'b0;
      ghost_tick  <= 1'b0;
      tick_lost   <= 1'b0;
      frame_count <= 16'd0;
      pac_cnt_r   <= 8'd0;
      ghost_cnt_r <= 8'd0;
      wd_r        <= 22'd0;
    end else begin
      state_r     <= state_next;
      frame_tick  <= frame_next;
      pac_tick    <= pac_next;
      ghost_tick  <= ghost_next;
      tick_lost   <= lost_next;
      frame_count <= count_next;
      pac_cnt_r   <= pac_cnt_next;
      ghost_cnt_r <= ghost_cnt_next;
      wd_r        <= wd_next;
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_frame_tick_sync.sv
// Directed bench for frame_tick_sync: alignment, dividers, watchdog, rising-only mode,
// frame counter wrap, enable/edge collision and asynchronous reset.
module tb_frame_tick_sync;

  logic clk = 1'b0;
  logic reset, slow_clk, enable;

  logic        frame_tick, pac_tick, ghost_tick, tick_lost;
  logic [15:0] frame_count;
  logic [1:0]  state;

  logic        r_frame_tick, r_pac_tick, r_ghost_tick, r_tick_lost;
  logic [15:0] r_frame_count;
  logic [1:0]  r_state;

  int tests = 0;
  int fails = 0;
  int ft0 = 0, pt0 = 0, gt0 = 0, ft1 = 0;
  int snap;
  int n;

  frame_tick_sync #(.SYNC_STAGES(2), .EDGE_MODE(1), .PAC_DIV(4), .GHOST_DIV(5), .WD_LIMIT(50)) dut (
    .clk(clk), .reset(reset), .slow_clk(slow_clk), .enable(enable),
    .frame_tick(frame_tick), .pac_tick(pac_tick), .ghost_tick(ghost_tick),
    .frame_count(frame_count), .tick_lost(tick_lost), .state(state)
  );

  frame_tick_sync #(.SYNC_STAGES(2), .EDGE_MODE(0), .PAC_DIV(4), .GHOST_DIV(5), .WD_LIMIT(50)) dut_rise (
    .clk(clk), .reset(reset), .slow_clk(slow_clk), .enable(enable),
    .frame_tick(r_frame_tick), .pac_tick(r_pac_tick), .ghost_tick(r_ghost_tick),
    .frame_count(r_frame_count), .tick_lost(r_tick_lost), .state(r_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // advance to the next falling edge and tally the pulses seen there
  task automatic step();
    @(negedge clk);
    ft0 += int'(frame_tick);
    pt0 += int'(pac_tick);
    gt0 += int'(ghost_tick);
    ft1 += int'(r_frame_tick);
  endtask

  task automatic toggle();
    slow_clk = ~slow_clk;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    slow_clk = 1'b0;
    repeat (3) step();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_frame_tick", 32'(frame_tick), 32'd0);
    check_eq("rst_count", 32'(frame_count), 32'd0);
    check_eq("rst_lost", 32'(tick_lost), 32'd0);

    // alignment and dividers
    reset = 1'b0;
    enable = 1'b1;
    step();
    check_eq("arm_state", 32'(state), 32'd1);
    toggle();
    repeat (20) step();
    check_eq("align_no_tick", 32'(ft0), 32'd0);
    check_eq("align_run", 32'(state), 32'd2);
    for (int k = 1; k <= 20; k++) begin
      toggle();
      step();
      step();
      if (k == 1) check_eq("latency_early", 32'(frame_tick), 32'd0);
      step();
      check_eq("tick", 32'(frame_tick), 32'd1);
      check_eq("count", 32'(frame_count), 32'(k));
      check_eq("pac", 32'(pac_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
      check_eq("ghost", 32'(ghost_tick), (k % 5 == 0) ? 32'd1 : 32'd0);
      if (k < 20) repeat (17) step();
    end
    check_eq("total_frame", 32'(ft0), 32'd20);
    check_eq("total_pac", 32'(pt0), 32'd5);
    check_eq("total_ghost", 32'(gt0), 32'd4);
    check_eq("rise_only_ticks", 32'(ft1), 32'd10);

    // watchdog
    n = 0;
    while (state != 2'd3 && n < 200) begin
      step();
      n++;
    end
    check_eq("wd_cycles", 32'(n), 32'd50);
    check_eq("wd_lost", 32'(tick_lost), 32'd1);
    repeat (20) step();
    check_eq("no_tick_in_lost", 32'(ft0), 32'd20);
    toggle();
    repeat (3) step();
    check_eq("resume_tick", 32'(frame_tick), 32'd1);
    check_eq("resume_count", 32'(frame_count), 32'd21);
    check_eq("resume_lost_sticky", 32'(tick_lost), 32'd1);
    check_eq("resume_state", 32'(state), 32'd2);
    enable = 1'b0;
    step();
    check_eq("disable_state", 32'(state), 32'd0);
    check_eq("disable_lost", 32'(tick_lost), 32'd0);
    check_eq("idle_count_hold", 32'(frame_count), 32'd21);

    // enable dropped in the cycle the edge is detected
    enable = 1'b1;
    step();
    toggle();
    repeat (10) step();
    check_eq("rearm_run", 32'(state), 32'd2);
    check_eq("rearm_count", 32'(frame_count), 32'd0);
    snap = ft0;
    toggle();
    step();
    step();
    enable = 1'b0;
    step();
    check_eq("collide_tick", 32'(frame_tick), 32'd0);
    check_eq("collide_state", 32'(state), 32'd0);
    repeat (4) step();
    check_eq("collide_no_late_tick", 32'(ft0 - snap), 32'd0);

    // frame counter wrap with a toggle every clk cycle
    enable = 1'b1;
    step();
    for (int k = 0; k < 65536; k++) begin
      toggle();
      step();
    end
    step();
    step();
    check_eq("pre_wrap_count", 32'(frame_count), 32'd65535);
    check_eq("pre_wrap_tick", 32'(frame_tick), 32'd1);
    step();
    check_eq("gap_tick", 32'(frame_tick), 32'd0);
    toggle();
    repeat (3) step();
    check_eq("wrap_tick", 32'(frame_tick), 32'd1);
    check_eq("wrap_count", 32'(frame_count), 32'd0);
    check_eq("wrap_pac", 32'(pac_tick), 32'd1);
    check_eq("wrap_ghost", 32'(ghost_tick), 32'd0);
    check_eq("wrap_lost", 32'(tick_lost), 32'd0);

    // asynchronous reset while a tick is high
    toggle();
    repeat (3) step();
    check_eq("pre_reset_tick", 32'(frame_tick), 32'd1);
    check_eq("pre_reset_count", 32'(frame_count), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("areset_tick", 32'(frame_tick), 32'd0);
    check_eq("areset_pac", 32'(pac_tick), 32'd0);
    check_eq("areset_count", 32'(frame_count), 32'd0);
    check_eq("areset_state", 32'(state), 32'd0);
    check_eq("areset_lost", 32'(tick_lost), 32'd0);
    step();
    reset = 1'b0;
    step();
    snap = ft0;
    toggle();
    repeat (6) step();
    check_eq("post_reset_consumed", 32'(ft0 - snap), 32'd0);
    check_eq("post_reset_run", 32'(state), 32'd2);
    toggle();
    repeat (3) step();
    check_eq("post_reset_tick", 32'(frame_tick), 32'd1);
    check_eq("post_reset_count", 32'(frame_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_tick_sync.md
# frame_tick_sync

Consumer side of the game's slow frame clock: takes the toggling frame-rate signal produced by the clock reducer, synchronizes it into the `clk` domain, and turns each transition into a single-cycle `frame_tick` enable. It also derives per-actor movement ticks (Pacman, ghosts), counts frames and runs a watchdog that flags a stalled frame clock. All downstream game logic runs on `clk` gated by these pulses, never on the slow signal as a clock.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `slow_clk`; legal range 2..4.
- `EDGE_MODE`, 1: 1 = both edges of `slow_clk` are frame events; 0 = rising edges only.
- `PAC_DIV`, 4: `pac_tick` fires on every PAC_DIV-th frame tick; legal range 1..255.
- `GHOST_DIV`, 5: `ghost_tick` fires on every GHOST_DIV-th frame tick; legal range 1..255.
- `WD_LIMIT`, 2_000_000: `clk` cycles without an accepted edge before the block declares the frame clock lost; must be less than 2^22.
- `clk` input 1: system clock; every register is on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `slow_clk` input 1: toggling frame signal, asynchronous to `clk`.
- `enable` input 1: level; low forces IDLE.
- `frame_tick` output 1: one-cycle pulse per accepted edge.
- `pac_tick` output 1: one-cycle pulse, coincident with `frame_tick`.
- `ghost_tick` output 1: one-cycle pulse, coincident with `frame_tick`.
- `frame_count` output 16: number of frame ticks since arming.
- `tick_lost` output 1: sticky watchdog flag.
- `state` output 2: IDLE=0, ARM=1, RUN=2, LOST=3.

## Operation
- Reset values:
  - All synchronizer flops and the previous-level flop = 0.
  - `state` = IDLE.
  - `frame_tick`, `pac_tick`, `ghost_tick`, `tick_lost` = 0.
  - `frame_count` = 0; divider counters and watchdog counter = 0.
- Edge detect:
  - Compare the last synchronizer stage with a previous-level flop.
  - With EDGE_MODE=0, only a 0→1 transition counts as an edge.
- IDLE:
  - Outputs quiet; `frame_count` holds its value; `tick_lost` cleared.
  - `enable`=1 → ARM.
- ARM:
  - On entry: clear `frame_count`, both dividers and the watchdog.
  - The first detected edge is consumed silently (phase alignment, no tick) → RUN.
  - The watchdog does not run in ARM.
- RUN:
  - Each edge produces `frame_tick`=1 for one cycle and increments `frame_count`; it wraps 65535→0 with no flag.
  - Pac divider counts 0..PAC_DIV-1 on frame ticks; `pac_tick` fires on the tick where it wraps to 0. The first `pac_tick` is on the PAC_DIV-th frame tick after ARM.
  - Ghost divider behaves the same way using GHOST_DIV.
  - A DIV of 1 makes that tick equal to `frame_tick`.
  - The 22-bit watchdog counter clears on every edge and otherwise increments. Reaching WD_LIMIT → LOST, sets `tick_lost`=1, counter stops.
- LOST:
  - No ticks are issued while in LOST.
  - The next edge → RUN and issues a normal `frame_tick`; counters and dividers continue from held values.
  - `tick_lost` stays 1 until IDLE or reset.
- `enable`=0 in any state → IDLE on the next edge of `clk`; any tick pending that cycle is suppressed.

## Timing
- Latency: a `slow_clk` transition sampled at `clk` edge k gives `frame_tick` high during the cycle after edge k+SYNC_STAGES (registered output). With defaults, that is 3 rising edges after first sampling.
- `pac_tick`/`ghost_tick` are registered in the same cycle as `frame_tick`; they are never high while `frame_tick` is low.
- `frame_count` shows the incremented value in the same cycle that `frame_tick` is high.
- Simultaneous events:
  - `enable` fall with an edge → enable wins, no tick.
  - Watchdog reaching WD_LIMIT with an edge → edge wins: stay in RUN, counter cleared, tick issued.
  - Edge in the cycle of entering ARM → it is the consumed alignment edge.
- Asynchronous `reset` mid-frame clears immediately. The first edge after reset release is still consumed in ARM.
- `slow_clk` pulses narrower than one `clk` period may be missed; this is legal, and the watchdog covers the consequence.

## Test plan
- Bench params: SYNC_STAGES=2, EDGE_MODE=1, PAC_DIV=4, GHOST_DIV=5, WD_LIMIT=50.
- Reset and alignment: hold `reset`, then release, `enable`=1, toggle `slow_clk` every 20 cycles. Expect the first toggle to produce no tick, then `frame_tick` 3 edges after each toggle; `frame_count`=1,2,3…
- Dividers: 20 frame ticks → `pac_tick` on ticks 4,8,12,16,20; `ghost_tick` on ticks 5,10,15,20; on tick 20 both are high together with `frame_tick`.
- Watchdog: stop toggling in RUN → `state`=LOST and `tick_lost`=1 exactly 50 cycles after the last accepted edge, with no ticks after that. Resume toggling → `frame_tick` returns, `tick_lost` stays 1. Then `enable`=0 → `tick_lost`=0, `state`=IDLE.
- EDGE_MODE=0: same stimulus as the alignment test → ticks only on rising edges, i.e. half the rate of the both-edge case.
- Wrap and edge cases:
  - Preload via 65536 ticks (fast toggling) → `frame_count` goes 65535→0.
  - `enable` dropped in the same cycle as an edge → no tick, `state`=IDLE.
  - `reset` pulsed mid-run → all outputs 0 in the same cycle.
